data_ram_responder: RTL and testbench
=====================================

Name: data_ram_responder

Overview:
- Memory-side responder for the data-access requests the MEM stage issues after the EX/MEM pipeline register.
- Accepts read/write requests with byte-lane select, write data and address, and services them from an on-chip word-organised RAM.
- Has a configurable number of wait states.
- Returns read data with a one-cycle ready pulse and raises a stall request so the pipeline holds while an access is in flight.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words; the word index is addr[DEPTH_LOG2+1:2].
- WAIT_CYCLES, 1, extra wait states between accept and response (0..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_read_flag  in  1  read request.
- mem_write_flag  in  1  write request; takes priority if both flags are set.
- mem_sel  in  `MEM_SEL_BUS_WIDTH (4)  byte-lane enables; bit i selects byte i.
- mem_addr  in  `ADDR_BUS_WIDTH (32)  byte address; bits [1:0] are ignored.
- mem_write_data  in  `DATA_BUS_WIDTH (32)  write data, lane-aligned.
- ready  out  1  one-cycle pulse: the response is complete.
- read_data  out  `DATA_BUS_WIDTH  full word read; lane extraction and sign extension happen in the MEM stage.
- stall_req  out  1  request to hold the pipeline.
- addr_err  out  1  only present with DRAM_BOUND_CHECK_EN; see Optional Feature.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, wait counter=0, ready=0, read_data=0, stall_req=0.
  - RAM contents are not cleared.
- A request is present when req = mem_read_flag | mem_write_flag.
- Inputs are held stable by the pipeline while stall_req=1; the block re-samples nothing after accept.
- State IDLE:
  - stall_req = req (combinational).
  - If req=1: latch addr/sel/wdata/we, load counter=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
- State WAIT:
  - stall_req=1.
  - Counter decrements each cycle; at counter==1, next state is RESP.
- State RESP:
  - ready=1 and stall_req=0 for exactly one cycle; next state is IDLE.
  - A req seen in RESP is not accepted; it is accepted in the following IDLE cycle.
- Latency: ready asserts WAIT_CYCLES+1 cycles after the accept edge.
  - WAIT_CYCLES=0: accept at edge N, ready high in the cycle after edge N.
- Write:
  - RAM bytes with sel[i]=1 are updated on the edge entering RESP; bytes with sel[i]=0 are untouched.
  - sel=0 with a write performs the full handshake and changes no bytes.
  - read_data is unchanged by a write.
- Read:
  - read_data is registered on the edge entering RESP and holds its value until the next read response or reset.
  - It ignores sel; the full word is returned.
- Read immediately following a write to the same word returns the new data (write committed before the next accept).
- Both flags set: treated as a write only.
- Reset asserted mid-access: the access is abandoned and no RAM write occurs unless the commit edge has already passed; the block returns to IDLE with ready=0.
- Counter width is 4 bits. WAIT_CYCLES>15 is a parameter error, caught by an elaboration-time check.

Optional Feature:
- Macro: DRAM_BOUND_CHECK_EN.
- Defined:
  - addr_err port exists.
  - If any of mem_addr[31:DEPTH_LOG2+2] is nonzero, the access still completes with normal latency.
  - The write is suppressed, read_data=0, and addr_err=1 during the ready cycle (0 otherwise; reset value 0).
- Undefined:
  - No addr_err port.
  - Upper address bits are ignored and the RAM aliases across the address space.

Decomposition:
- bus.v supplies DATA_BUS, ADDR_BUS and MEM_SEL_BUS with their _WIDTH constants.
- New `DRAM_STATE_BUS and the state encodings IDLE/WAIT/RESP are added there.
- Sub-module dram_array: 2^DEPTH_LOG2 x 32 storage.
  - Four independent byte-lane write enables.
  - Synchronous read port; no reset.
- data_ram_responder contains the FSM, counter, request latch and bound check.

Test Plan:
- Reset: hold rst=0 while driving mem_write_flag=1 -> ready=0, stall_req=0, read_data=0; release, no RAM change.
- WAIT_CYCLES=1: write sel=4'b1111, addr=0x10, data=0xDEADBEEF -> stall_req=1 for 2 cycles, ready in cycle 3; then read addr=0x10 -> read_data=0xDEADBEEF.
- Byte lanes: after 0xDEADBEEF at 0x10, write sel=4'b0010 data=0x00005500 -> read returns 0xDEAD55EF; sel=0 write leaves 0xDEAD55EF.
- WAIT_CYCLES=0: back-to-back write 0x11223344 then read at 0x20 -> each ready 1 cycle after accept; read returns 0x11223344; req held during RESP is accepted only the next cycle.
- Reset mid-WAIT (WAIT_CYCLES=3, write 0xAAAAAAAA to a word holding 0x12345678, rst=0 after 1 wait cycle) -> no ready, word still 0x12345678.
- DRAM_BOUND_CHECK_EN, DEPTH_LOG2=10: write addr=0x1000 -> addr_err=1 with ready, word 0 unchanged; undefined macro: same write aliases to word 0.

Source files
------------

// File: rtl/data_ram_responder_pkg.sv
// data_ram_responder_pkg: shared bus widths, responder state encoding and the
// address range helper used by the optional bound check.
package data_ram_responder_pkg;

    localparam int DATA_BUS_WIDTH       = 32;
    localparam int ADDR_BUS_WIDTH       = 32;
    localparam int MEM_SEL_BUS_WIDTH    = 4;
    localparam int DRAM_STATE_BUS_WIDTH = 2;
    localparam int WAIT_CNT_WIDTH       = 4;
    localparam int WAIT_CYCLES_MAX      = 15;

    typedef enum logic [DRAM_STATE_BUS_WIDTH-1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dram_state_e;

    // True when no address bit above the RAM's word index is set
    function automatic logic addr_in_range(input logic [ADDR_BUS_WIDTH-1:0] addr,
                                           input int depth_log2);
        logic [ADDR_BUS_WIDTH-1:0] upper;
        upper = addr >> (depth_log2 + 2);
        return (upper == '0);
    endfunction

endpackage

// File: rtl/data_ram_responder_dram_array.sv
// dram_array: word-organised data RAM with four byte-lane write enables and
// a registered read port. Contents are never reset.
module dram_array
    import data_ram_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [MEM_SEL_BUS_WIDTH-1:0] byte_en,
    input  logic [DEPTH_LOG2-1:0]        index,
    input  logic [DATA_BUS_WIDTH-1:0]    wdata,
    input  logic                         re,
    output logic [DATA_BUS_WIDTH-1:0]    rdata
);

    logic [DATA_BUS_WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Byte-lane writes: only lanes with their enable set are updated
    always_ff @(posedge clk) begin
        if (we) begin
            for (int lane = 0; lane < MEM_SEL_BUS_WIDTH; lane++) begin
                if (byte_en[lane]) begin
                    mem[index][lane*8 +: 8] <= wdata[lane*8 +: 8];
                end
            end
        end
    end

    // Synchronous full-word read; the output holds between read strobes
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/data_ram_responder.sv
// data_ram_responder: MEM-stage data RAM responder. Accepts one read or write,
// stalls the pipeline for WAIT_CYCLES wait states, then pulses ready for one
// cycle. Optional macro DRAM_BOUND_CHECK_EN adds the addr_err output and
// blocks accesses whose address lies beyond the RAM.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_read_flag,
    input  logic                         mem_write_flag,
    input  logic [MEM_SEL_BUS_WIDTH-1:0] mem_sel,
    input  logic [ADDR_BUS_WIDTH-1:0]    mem_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    mem_write_data,
    output logic                         ready,
    output logic [DATA_BUS_WIDTH-1:0]    read_data,
    output logic                         stall_req
`ifdef DRAM_BOUND_CHECK_EN
    ,
    output logic                         addr_err
`endif
);

    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_CYCLES);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_CYCLES_MAX) begin : g_bad_wait_cycles
            $error("data_ram_responder: WAIT_CYCLES must lie in 0..15");
        end
    endgenerate

    dram_state_e                  state;
    dram_state_e                  next_state;
    logic [WAIT_CNT_WIDTH-1:0]    wait_cnt;
    logic                         req;
    logic                         accept;
    logic                         commit;

    logic                         we_q;
    logic [MEM_SEL_BUS_WIDTH-1:0] sel_q;
    logic [DEPTH_LOG2-1:0]        index_q;
    logic [DATA_BUS_WIDTH-1:0]    wdata_q;
    logic                         read_zero_q;

    logic                         acc_we;
    logic [MEM_SEL_BUS_WIDTH-1:0] acc_sel;
    logic [DEPTH_LOG2-1:0]        acc_index;
    logic [DATA_BUS_WIDTH-1:0]    acc_wdata;
    logic                         acc_in_range;
    logic [DATA_BUS_WIDTH-1:0]    array_rdata;
    logic                         unused_addr_bits;

`ifdef DRAM_BOUND_CHECK_EN
    logic                         in_range_q;
    logic                         err_q;
`endif

    // The byte offset bits never matter; the upper bits only matter with the bound check
    assign unused_addr_bits = ^{mem_addr[1:0], mem_addr[ADDR_BUS_WIDTH-1:DEPTH_LOG2+2]};

    // Next state, handshake outputs and the RAM commit strobe; reset gates anything that could touch the RAM
    always_comb begin
        req        = mem_read_flag | mem_write_flag;
        next_state = state;
        stall_req  = 1'b0;
        ready      = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                stall_req = req & rst;
                accept    = req & rst;
                commit    = accept && (WAIT_LOAD == '0);
                if (req) begin
                    next_state = (WAIT_LOAD == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                stall_req = 1'b1;
                if (wait_cnt == WAIT_CNT_WIDTH'(1)) begin
                    next_state = RESP;
                    commit     = rst;
                end
            end
            RESP: begin
                ready      = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // With zero wait states the access commits on the accept edge, so IDLE uses the live request fields
    always_comb begin
        acc_we    = we_q;
        acc_sel   = sel_q;
        acc_index = index_q;
        acc_wdata = wdata_q;
        if (state == IDLE) begin
            acc_we    = mem_write_flag;
            acc_sel   = mem_sel;
            acc_index = mem_addr[DEPTH_LOG2+1:2];
            acc_wdata = mem_write_data;
        end
`ifdef DRAM_BOUND_CHECK_EN
        acc_in_range = (state == IDLE) ? addr_in_range(mem_addr, DEPTH_LOG2) : in_range_q;
`else
        acc_in_range = 1'b1;
`endif
    end

    // State register, wait counter, request latch and read-data masking flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            index_q     <= '0;
            wdata_q     <= '0;
            read_zero_q <= 1'b1;
        end else begin
            state <= next_state;
            if (accept) begin
                wait_cnt <= WAIT_LOAD;
                we_q     <= mem_write_flag;
                sel_q    <= mem_sel;
                index_q  <= mem_addr[DEPTH_LOG2+1:2];
                wdata_q  <= mem_write_data;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (commit && !acc_we) begin
                read_zero_q <= !acc_in_range;
            end
        end
    end

`ifdef DRAM_BOUND_CHECK_EN
    // Remember whether the accepted address fits the RAM and flag it in the response cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_range_q <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                in_range_q <= addr_in_range(mem_addr, DEPTH_LOG2);
            end
            if (commit) begin
                err_q <= !acc_in_range;
            end
        end
    end

    assign addr_err = (state == RESP) && err_q;
`endif

    assign read_data = read_zero_q ? '0 : array_rdata;

    dram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_dram_array (
        .clk     (clk),
        .we      (commit && acc_we && acc_in_range),
        .byte_en (acc_sel),
        .index   (acc_index),
        .wdata   (acc_wdata),
        .re      (commit && !acc_we),
        .rdata   (array_rdata)
    );

endmodule

// File: tb/tb_data_ram_responder.sv
// tb_data_ram_responder: three responders (0, 1 and 3 wait states) driven by
// directed and random accesses, checked against a word-array memory model.
`timescale 1ns/1ps
module tb_data_ram_responder;

    localparam int NUM_DUT    = 3;
    localparam int DEPTH_LOG2 = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_flag  [NUM_DUT];
    logic        write_flag [NUM_DUT];
    logic [3:0]  sel        [NUM_DUT];
    logic [31:0] addr       [NUM_DUT];
    logic [31:0] wdata      [NUM_DUT];
    logic        ready      [NUM_DUT];
    logic [31:0] read_data  [NUM_DUT];
    logic        stall_req  [NUM_DUT];
`ifdef DRAM_BOUND_CHECK_EN
    logic        addr_err   [NUM_DUT];
`endif

    int          checkCount = 0;
    int          errorCount = 0;
    logic [31:0] modelMem  [NUM_DUT][2**DEPTH_LOG2];
    logic [31:0] modelRead [NUM_DUT];
    logic [31:0] addrPool  [9];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NUM_DUT; g++) begin : g_dut
            data_ram_responder #(
                .DEPTH_LOG2  (DEPTH_LOG2),
                .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
            ) u_dut (
                .clk            (clk),
                .rst            (rst),
                .mem_read_flag  (read_flag[g]),
                .mem_write_flag (write_flag[g]),
                .mem_sel        (sel[g]),
                .mem_addr       (addr[g]),
                .mem_write_data (wdata[g]),
                .ready          (ready[g]),
                .read_data      (read_data[g]),
                .stall_req      (stall_req[g])
`ifdef DRAM_BOUND_CHECK_EN
                ,
                .addr_err       (addr_err[g])
`endif
            );
        end
    endgenerate

    function automatic int waitCyclesOf(input int inst);
        return (inst == 0) ? 0 : ((inst == 1) ? 1 : 3);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Runs one full access on an idle responder; chainRead presents a read during the ready cycle
    task automatic applyStimulus(input int inst, input bit we, input bit re, input logic [3:0] s,
                                 input logic [31:0] a, input logic [31:0] d, input bit chainRead);
        int lat;
        bit seen;
        bit ok;
        int wi;
        write_flag[inst] = we;
        read_flag[inst]  = re;
        sel[inst]        = s;
        addr[inst]       = a;
        wdata[inst]      = d;
        #1;
        checkOutput("stall_idle", stall_req[inst], 1'b1);
        lat  = -1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (ready[inst]) begin
                seen = 1'b1;
                lat  = k;
            end else begin
                checkOutput("stall_wait", stall_req[inst], 1'b1);
            end
        end
        if (!seen) begin
            checkOutput("ready_timeout", ready[inst], 1'b1);
        end else begin
            checkOutput("latency", 32'(lat), 32'(waitCyclesOf(inst)));
            checkOutput("stall_resp", stall_req[inst], 1'b0);
            wi = int'(a[DEPTH_LOG2+1:2]);
`ifdef DRAM_BOUND_CHECK_EN
            ok = (a < (32'd4 << DEPTH_LOG2));
            checkOutput("addr_err", addr_err[inst], !ok);
`else
            ok = 1'b1;
`endif
            if (we) begin
                if (ok) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s[b]) modelMem[inst][wi][b*8 +: 8] = d[b*8 +: 8];
                    end
                end
            end else begin
                modelRead[inst] = ok ? modelMem[inst][wi] : 32'h0;
            end
            checkOutput("read_data", read_data[inst], modelRead[inst]);
        end
        write_flag[inst] = 1'b0;
        read_flag[inst]  = chainRead;
        @(posedge clk);
        #1;
        checkOutput("ready_pulse", ready[inst], 1'b0);
        checkOutput("stall_after", stall_req[inst], chainRead);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        addrPool = '{32'h0, 32'h10, 32'h20, 32'h40, 32'h80, 32'h3FC,
                     32'h1000, 32'hFFFFF010, 32'h0040_0080};
        for (int i = 0; i < NUM_DUT; i++) begin
            read_flag[i]  = 1'b0;
            write_flag[i] = 1'b1;
            sel[i]        = 4'hF;
            addr[i]       = 32'h10;
            wdata[i]      = 32'hCAFEF00D;
            modelRead[i]  = 32'h0;
        end

        // Reset held while a write is requested
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NUM_DUT; i++) begin
            checkOutput("reset_ready", ready[i], 1'b0);
            checkOutput("reset_stall", stall_req[i], 1'b0);
            checkOutput("reset_rdata", read_data[i], 32'h0);
            write_flag[i] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // One wait state: full write, readback, byte lanes and empty lane mask
        applyStimulus(1, 1, 0, 4'hF, 32'h10, 32'hDEADBEEF, 0);
        applyStimulus(1, 0, 1, 4'hF, 32'h10, 32'h0, 0);
        checkOutput("wc1_readback", read_data[1], 32'hDEADBEEF);
        applyStimulus(1, 1, 0, 4'b0010, 32'h10, 32'h00005500, 0);
        applyStimulus(1, 0, 1, 4'h0, 32'h10, 32'h0, 0);
        checkOutput("lane_write", read_data[1], 32'hDEAD55EF);
        applyStimulus(1, 1, 0, 4'h0, 32'h10, 32'hFFFFFFFF, 0);
        applyStimulus(1, 0, 1, 4'hF, 32'h10, 32'h0, 0);
        checkOutput("sel_zero_write", read_data[1], 32'hDEAD55EF);

        // Zero wait states: write then read presented during the ready cycle
        applyStimulus(0, 1, 0, 4'hF, 32'h20, 32'h11223344, 1);
        applyStimulus(0, 0, 1, 4'hF, 32'h20, 32'h0, 0);
        checkOutput("wc0_readback", read_data[0], 32'h11223344);

        // Three wait states: reset after one wait cycle abandons the write
        applyStimulus(2, 1, 0, 4'hF, 32'h40, 32'h12345678, 0);
        write_flag[2] = 1'b1;
        sel[2]        = 4'hF;
        addr[2]       = 32'h40;
        wdata[2]      = 32'hAAAAAAAA;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midreset_ready", ready[2], 1'b0);
        checkOutput("midreset_stall", stall_req[2], 1'b0);
        write_flag[2] = 1'b0;
        for (int i = 0; i < NUM_DUT; i++) modelRead[i] = 32'h0;
        @(posedge clk);
        #1;
        checkOutput("midreset_ready_hold", ready[2], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(2, 0, 1, 4'hF, 32'h40, 32'h0, 0);
        checkOutput("midreset_word", read_data[2], 32'h12345678);

        // Address beyond the RAM: blocked with the bound check, aliases to word 0 without it
        applyStimulus(1, 1, 0, 4'hF, 32'h0, 32'h0BADF00D, 0);
        applyStimulus(1, 1, 0, 4'hF, 32'h1000, 32'h5A5A5A5A, 0);
        applyStimulus(1, 0, 1, 4'hF, 32'h0, 32'h0, 0);
`ifdef DRAM_BOUND_CHECK_EN
        checkOutput("bound_word0", read_data[1], 32'h0BADF00D);
`else
        checkOutput("alias_word0", read_data[1], 32'h5A5A5A5A);
`endif

        // Random accesses over a small pool of words, including aliased addresses
        for (int inst = 0; inst < NUM_DUT; inst++) begin
            for (int p = 0; p < 6; p++) begin
                applyStimulus(inst, 1, 0, 4'hF, addrPool[p], $urandom, 0);
            end
            for (int n = 0; n < 30; n++) begin
                int          kind;
                logic [31:0] a;
                bit          chain;
                kind  = int'($urandom_range(0, 3));
                a     = addrPool[$urandom_range(0, 8)] | 32'($urandom_range(0, 3));
                chain = ($urandom_range(0, 3) == 0);
                applyStimulus(inst, (kind == 0 || kind == 2), (kind != 0), 4'($urandom), a, $urandom, chain);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
